// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the Wishbone memory arbiter slice.
package wb_arb_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADR_W  = 12;
  localparam int unsigned SEL_W  = 16;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;

endpackage

// File: rtl/wishbone.sv
// Wishbone bundle carrying 128-bit lines, 12-bit line address and 16-bit SEL.
interface wishbone;
  import wb_arb_pkg::*;

  logic [DATA_W-1:0] DAT_M;
  logic [DATA_W-1:0] DAT_S;
  logic [ADR_W-1:0]  ADR;
  logic [SEL_W-1:0]  SEL;
  logic              WE;
  logic              CYC;
  logic              STB;
  logic              ACK;
  logic              RTY;

  modport master (
    output DAT_M, ADR, SEL, WE, CYC, STB,
    input  DAT_S, ACK, RTY
  );

  modport slave (
    input  DAT_M, ADR, SEL, WE, CYC, STB,
    output DAT_S, ACK, RTY
  );

endinterface

// File: rtl/wb_arb_timer.sv
// Saturating cycle counter with synchronous clear and count enable;
// done is high while the count sits at MAX.
module wb_arb_timer #(
  parameter int unsigned MAX = 255,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == W'(MAX));

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master Wishbone arbiter (I-cache, D-cache) in front of
// physical memory; grant is registered and held until ACK/RTY/abort/timeout.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic     CLK,
  input  logic     RST_N,
  wishbone.slave   ic,
  wishbone.slave   dc,
  wishbone.master  mem,
  output logic     timeout_o
);

  arb_state_t state, state_nx;
  arb_src_t   last_gnt, last_gnt_nx;

  logic req_i, req_d;
  logic gnt_i, gnt_d, granted;
  logic own_cyc;
  logic live;
  logic tmo_done, tmo_hit;
  logic fwd_ack, fwd_rty, tmo_fire;
  logic release_gnt;

  assign req_i   = ic.CYC & ic.STB;
  assign req_d   = dc.CYC & dc.STB;
  assign gnt_i   = (state == GNT_I);
  assign gnt_d   = (state == GNT_D);
  assign granted = gnt_i | gnt_d;
  assign own_cyc = gnt_i ? ic.CYC : dc.CYC;
  assign live    = granted & own_cyc;
  assign tmo_hit = granted & tmo_done;

  // ACK beats RTY, RTY beats timeout; nothing is returned once the owner aborts.
  assign fwd_ack     = live & mem.ACK;
  assign fwd_rty     = live & ~mem.ACK & (mem.RTY | tmo_hit);
  assign tmo_fire    = live & ~mem.ACK & ~mem.RTY & tmo_hit;
  assign release_gnt = granted & (~own_cyc | mem.ACK | mem.RTY | tmo_hit);

  wb_arb_timer #(
    .MAX (TIMEOUT),
    .W   (CNT_W)
  ) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (state == IDLE),
    .en    (granted & ~mem.ACK & ~mem.RTY),
    .done  (tmo_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      last_gnt <= SRC_D;
    end else begin
      state    <= state_nx;
      last_gnt <= last_gnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    unique case (state)
      IDLE: begin
        if (req_i && (!req_d || (last_gnt == SRC_D))) begin
          state_nx = GNT_I;
        end else if (req_d) begin
          state_nx = GNT_D;
        end
      end
      GNT_I: begin
        if (release_gnt) begin
          state_nx    = IDLE;
          last_gnt_nx = SRC_I;
        end
      end
      GNT_D: begin
        if (release_gnt) begin
          state_nx    = IDLE;
          last_gnt_nx = SRC_D;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Forward path mirrors the owner; the timeout cycle withdraws CYC/STB from memory.
  always_comb begin
    mem.CYC   = 1'b0;
    mem.STB   = 1'b0;
    mem.WE    = 1'b0;
    mem.ADR   = '0;
    mem.SEL   = '0;
    mem.DAT_M = '0;
    if (gnt_i) begin
      mem.CYC   = ic.CYC;
      mem.STB   = ic.STB;
      mem.WE    = ic.WE;
      mem.ADR   = ic.ADR;
      mem.SEL   = ic.SEL;
      mem.DAT_M = ic.DAT_M;
    end else if (gnt_d) begin
      mem.CYC   = dc.CYC;
      mem.STB   = dc.STB;
      mem.WE    = dc.WE;
      mem.ADR   = dc.ADR;
      mem.SEL   = dc.SEL;
      mem.DAT_M = dc.DAT_M;
    end
    if (tmo_hit) begin
      mem.CYC = 1'b0;
      mem.STB = 1'b0;
    end
  end

  always_comb begin
    ic.DAT_S = mem.DAT_S;
    dc.DAT_S = mem.DAT_S;
    ic.ACK   = gnt_i & fwd_ack;
    ic.RTY   = gnt_i & fwd_rty;
    dc.ACK   = gnt_d & fwd_ack;
    dc.RTY   = gnt_d & fwd_rty;
    timeout_o = tmo_fire;
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: scenario tasks against a
// transaction-level model of round-robin service and cycle timing.
module tb_wb_mem_arbiter;

  typedef struct packed {
    logic [11:0]  adr;
    logic         we;
    logic [15:0]  sel;
    logic [127:0] dm;
    logic [127:0] ds;
  } txn_t;

  logic CLK = 1'b0;
  logic RST_N;
  logic timeout_o;

  wishbone ic_bus ();
  wishbone dc_bus ();
  wishbone mem_bus ();

  wb_mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ic        (ic_bus),
    .dc        (dc_bus),
    .mem       (mem_bus),
    .timeout_o (timeout_o)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          last_srv;   // 0 = I, 1 = D (model of most recently served port)

  // Memory responder: ACKs mem_lat cycles after the first STB cycle (mode 0),
  // or stays silent (mode 1). man_ack/man_rty inject responses directly.
  int   mem_lat;
  int   mem_mode;
  int   stb_cnt;
  logic auto_ack, man_ack, man_rty;

  assign mem_bus.ACK = auto_ack | man_ack;
  assign mem_bus.RTY = man_rty;

  always @(negedge CLK) begin
    if (mem_bus.CYC && mem_bus.STB && !mem_bus.ACK && !mem_bus.RTY) stb_cnt = stb_cnt + 1;
    else stb_cnt = 0;
  end

  always @(posedge CLK) begin
    #1;
    auto_ack = (mem_mode == 0) && (stb_cnt == mem_lat);
  end

  function automatic txn_t rand_txn();
    txn_t r;
    r.adr = 12'($urandom);
    r.we  = 1'($urandom);
    r.sel = 16'($urandom);
    r.dm  = {$urandom, $urandom, $urandom, $urandom};
    r.ds  = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic drive_req(input int p, input txn_t t);
    if (p == 0) begin
      ic_bus.CYC = 1'b1; ic_bus.STB = 1'b1; ic_bus.WE = t.we;
      ic_bus.ADR = t.adr; ic_bus.SEL = t.sel; ic_bus.DAT_M = t.dm;
    end else begin
      dc_bus.CYC = 1'b1; dc_bus.STB = 1'b1; dc_bus.WE = t.we;
      dc_bus.ADR = t.adr; dc_bus.SEL = t.sel; dc_bus.DAT_M = t.dm;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) begin ic_bus.CYC = 1'b0; ic_bus.STB = 1'b0; end
    else begin dc_bus.CYC = 1'b0; dc_bus.STB = 1'b0; end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // One or two simultaneous requests; model predicts winner, mem window and ACK cycle.
  task automatic run_pair(input bit use_i, input bit use_d, input int lat,
                          input txn_t ti, input txn_t td);
    int   n, first, second, ack1, ack2, stop;
    txn_t tf, ts;
    n = int'(use_i) + int'(use_d);
    if (n == 2) first = (last_srv == 1) ? 0 : 1;
    else        first = use_i ? 0 : 1;
    second = 1 - first;
    tf = (first == 0) ? ti : td;
    ts = (second == 0) ? ti : td;
    ack1 = 1 + lat;
    ack2 = 3 + 2 * lat;
    stop = (n == 2) ? ack2 + 1 : ack1 + 1;
    mem_lat  = lat;
    mem_mode = 0;
    if (use_i) drive_req(0, ti);
    if (use_d) drive_req(1, td);
    mem_bus.DAT_S = tf.ds;
    for (int k = 0; k <= stop; k++) begin
      int   own;
      txn_t t;
      logic ei, ed;
      @(negedge CLK);
      own = -1;
      if (k >= 1 && k <= ack1) own = first;
      else if (n == 2 && k >= ack1 + 2 && k <= ack2) own = second;
      t = (own == first) ? tf : ts;
      n_cmp++;
      if (mem_bus.CYC !== (own >= 0)) begin
        n_bad++;
        $display("FAIL mem_cyc k=%0d: got %b want %b", k, mem_bus.CYC, (own >= 0));
      end
      if (own >= 0) begin
        n_cmp++;
        if ({mem_bus.STB, mem_bus.WE, mem_bus.ADR, mem_bus.SEL, mem_bus.DAT_M}
            !== {1'b1, t.we, t.adr, t.sel, t.dm}) begin
          n_bad++;
          $display("FAIL mem_mirror k=%0d: got stb=%b we=%b adr=%h sel=%h dat=%h want stb=1 we=%b adr=%h sel=%h dat=%h",
                   k, mem_bus.STB, mem_bus.WE, mem_bus.ADR, mem_bus.SEL, mem_bus.DAT_M,
                   t.we, t.adr, t.sel, t.dm);
        end
      end
      ei = (k == ack1 && first == 0) || (n == 2 && k == ack2 && second == 0);
      ed = (k == ack1 && first == 1) || (n == 2 && k == ack2 && second == 1);
      n_cmp++;
      if ({ic_bus.ACK, dc_bus.ACK, ic_bus.RTY, dc_bus.RTY, timeout_o} !== {ei, ed, 3'b000}) begin
        n_bad++;
        $display("FAIL ack_route k=%0d: got iack/dack/irty/drty/to=%b want %b",
                 k, {ic_bus.ACK, dc_bus.ACK, ic_bus.RTY, dc_bus.RTY, timeout_o},
                 {ei, ed, 3'b000});
      end
      if (ei || ed) begin
        n_cmp++;
        if ((ei ? ic_bus.DAT_S : dc_bus.DAT_S) !== t.ds) begin
          n_bad++;
          $display("FAIL ack_data k=%0d: got %h want %h", k,
                   (ei ? ic_bus.DAT_S : dc_bus.DAT_S), t.ds);
        end
      end
      tick();
      if (k == ack1) begin drop_req(first); mem_bus.DAT_S = ts.ds; end
      if (n == 2 && k == ack2) drop_req(second);
    end
    last_srv = (n == 2) ? second : first;
  endtask

  task automatic test_reset();
    ic_bus.CYC = 1'b1; ic_bus.STB = 1'b1; ic_bus.WE = 1'b1; ic_bus.ADR = 12'hFFF;
    dc_bus.CYC = 1'b1; dc_bus.STB = 1'b1; man_ack = 1'b1; man_rty = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    n_cmp++;
    if ({mem_bus.CYC, mem_bus.STB, mem_bus.WE, mem_bus.ADR, mem_bus.SEL, mem_bus.DAT_M} !== '0) begin
      n_bad++;
      $display("FAIL reset_mem: got cyc=%b stb=%b we=%b adr=%h want all zero",
               mem_bus.CYC, mem_bus.STB, mem_bus.WE, mem_bus.ADR);
    end
    n_cmp++;
    if ({ic_bus.ACK, ic_bus.RTY, dc_bus.ACK, dc_bus.RTY, timeout_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_resp: got %b want 00000",
               {ic_bus.ACK, ic_bus.RTY, dc_bus.ACK, dc_bus.RTY, timeout_o});
    end
    drop_req(0); drop_req(1); ic_bus.WE = 1'b0; ic_bus.ADR = '0;
    man_ack = 1'b0; man_rty = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_ties();
    for (int i = 0; i < 4; i++) run_pair(1'b1, 1'b1, int'($urandom_range(1, 3)), rand_txn(), rand_txn());
  endtask

  task automatic test_single_read();
    txn_t ti;
    ti = rand_txn();
    ti.adr = 12'h040; ti.we = 1'b0; ti.ds = {16{8'hA5}};
    run_pair(1'b1, 1'b0, 3, ti, rand_txn());
  endtask

  task automatic test_write_hold();
    txn_t td;
    td = rand_txn();
    td.we = 1'b1; td.sel = 16'h00FF; td.dm = 128'h1234;
    run_pair(1'b1, 1'b1, 2, rand_txn(), td);
  endtask

  task automatic test_timeout();
    logic exp_cyc, exp_to;
    mem_mode = 1;
    drive_req(1, rand_txn());
    for (int k = 0; k <= 6; k++) begin
      @(negedge CLK);
      exp_cyc = (k >= 1 && k <= 4);
      exp_to  = (k == 5);
      n_cmp++;
      if ({mem_bus.CYC, mem_bus.STB} !== {exp_cyc, exp_cyc}) begin
        n_bad++;
        $display("FAIL tmo_mem k=%0d: got cyc/stb=%b%b want %b%b", k,
                 mem_bus.CYC, mem_bus.STB, exp_cyc, exp_cyc);
      end
      n_cmp++;
      if ({dc_bus.RTY, timeout_o, dc_bus.ACK, ic_bus.RTY, ic_bus.ACK} !== {exp_to, exp_to, 3'b000}) begin
        n_bad++;
        $display("FAIL tmo_resp k=%0d: got drty/to/dack/irty/iack=%b want %b", k,
                 {dc_bus.RTY, timeout_o, dc_bus.ACK, ic_bus.RTY, ic_bus.ACK},
                 {exp_to, exp_to, 3'b000});
      end
      tick();
      if (k == 5) drop_req(1);
    end
    mem_mode = 0;
    last_srv = 1;
    run_pair(1'b1, 1'b1, 2, rand_txn(), rand_txn());
  endtask

  task automatic test_abort();
    mem_mode = 0; mem_lat = 3;
    drive_req(1, rand_txn());
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      n_cmp++;
      if ({mem_bus.CYC, ic_bus.ACK, dc_bus.ACK, ic_bus.RTY, dc_bus.RTY}
          !== {(k == 1), 4'b0000}) begin
        n_bad++;
        $display("FAIL abort k=%0d: got cyc/iack/dack/irty/drty=%b want %b", k,
                 {mem_bus.CYC, ic_bus.ACK, dc_bus.ACK, ic_bus.RTY, dc_bus.RTY},
                 {(k == 1), 4'b0000});
      end
      tick();
      if (k == 1) drop_req(1);
      man_ack = (k == 2);
    end
    last_srv = 1;
    run_pair(1'b1, 1'b0, 1, rand_txn(), rand_txn());
  endtask

  task automatic test_retry();
    txn_t td;
    for (int b = 0; b < 2; b++) begin
      td = rand_txn();
      mem_mode = 1;
      drive_req(1, td);
      mem_bus.DAT_S = td.ds;
      for (int k = 0; k <= 3; k++) begin
        @(negedge CLK);
        n_cmp++;
        if ({dc_bus.ACK, dc_bus.RTY, ic_bus.ACK, ic_bus.RTY, timeout_o}
            !== {(k == 2 && b == 1), (k == 2 && b == 0), 3'b000}) begin
          n_bad++;
          $display("FAIL retry b=%0d k=%0d: got dack/drty/iack/irty/to=%b want %b", b, k,
                   {dc_bus.ACK, dc_bus.RTY, ic_bus.ACK, ic_bus.RTY, timeout_o},
                   {(k == 2 && b == 1), (k == 2 && b == 0), 3'b000});
        end
        if (k == 2 && b == 1) begin
          n_cmp++;
          if (dc_bus.DAT_S !== td.ds) begin
            n_bad++;
            $display("FAIL retry_data: got %h want %h", dc_bus.DAT_S, td.ds);
          end
        end
        tick();
        if (k == 1) begin man_rty = 1'b1; man_ack = (b == 1); end
        if (k == 2) begin man_rty = 1'b0; man_ack = 1'b0; drop_req(1); end
      end
    end
    mem_mode = 0;
    last_srv = 1;
    run_pair(1'b1, 1'b1, 1, rand_txn(), rand_txn());
  endtask

  task automatic test_async_reset();
    mem_mode = 1;
    drive_req(1, rand_txn());
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (mem_bus.CYC !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre: got cyc=%b want 1", mem_bus.CYC);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({mem_bus.CYC, mem_bus.STB, dc_bus.RTY, dc_bus.ACK} !== 4'b0000) begin
      n_bad++;
      $display("FAIL areset_drop: got cyc/stb/drty/dack=%b want 0000",
               {mem_bus.CYC, mem_bus.STB, dc_bus.RTY, dc_bus.ACK});
    end
    drop_req(1);
    mem_mode = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    last_srv = 1;
    run_pair(1'b1, 1'b1, 3, rand_txn(), rand_txn());
  endtask

  task automatic test_random();
    int pat;
    for (int i = 0; i < 30; i++) begin
      pat = int'($urandom_range(1, 3));
      run_pair(pat[0], pat[1], int'($urandom_range(1, 3)), rand_txn(), rand_txn());
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    last_srv = 1;
    mem_lat = 3; mem_mode = 0; stb_cnt = 0;
    auto_ack = 1'b0; man_ack = 1'b0; man_rty = 1'b0;
    mem_bus.DAT_S = '0;
    ic_bus.CYC = 1'b0; ic_bus.STB = 1'b0; ic_bus.WE = 1'b0;
    ic_bus.ADR = '0; ic_bus.SEL = '0; ic_bus.DAT_M = '0;
    dc_bus.CYC = 1'b0; dc_bus.STB = 1'b0; dc_bus.WE = 1'b0;
    dc_bus.ADR = '0; dc_bus.SEL = '0; dc_bus.DAT_M = '0;
    test_reset();
    test_ties();
    test_single_read();
    test_write_hold();
    test_timeout();
    test_abort();
    test_retry();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
